// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - packet-granular round-robin arbiter for two AXI-Stream sources
//
// Purpose: shares one downstream AXI-Stream between two sources. A grant is
// held from the first beat until the granted source's tlast beat is accepted.
// Simultaneous requests alternate between the sources.
//
// Optional feature: define ARB_PKT_COUNT_EN to add per-source completed-packet
// counters (parameter CountWidth, ports pkt_count0/pkt_count1).
//
// Ports:
//   counter_clk              clock, rising edge
//   reset                    synchronous active-high reset
//   s0_tdata/tvalid/tlast    source 0 stream in, s0_tready back to source 0
//   s1_tdata/tvalid/tlast    source 1 stream in, s1_tready back to source 1
//   m_tdata/tvalid/tlast     muxed stream out, m_tready from downstream
//   grant                    one-hot current owner, 2'b00 when idle
//   busy                     high while a packet is locked
//   pkt_count0/pkt_count1    completed packets per source (ARB_PKT_COUNT_EN only)
module axis_pkt_arbiter #(
  parameter int DataWidth = 32
`ifdef ARB_PKT_COUNT_EN
  ,
  parameter int CountWidth = 16
`endif
) (
  input  logic                 counter_clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] s0_tdata,
  input  logic                 s0_tvalid,
  output logic                 s0_tready,
  input  logic                 s0_tlast,
  input  logic [DataWidth-1:0] s1_tdata,
  input  logic                 s1_tvalid,
  output logic                 s1_tready,
  input  logic                 s1_tlast,
  output logic [DataWidth-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [1:0]           grant,
  output logic                 busy
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [CountWidth-1:0] pkt_count0,
  output logic [CountWidth-1:0] pkt_count1
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e state_q;
  logic   last_served_q;

  logic lock0;
  logic lock1;
  logic pkt_done;

  // Reset masks the lock decode so no beat can leave during the reset cycle,
  // even though the state register only clears at the end of it.
  assign lock0 = (state_q == LOCK0) & ~reset;
  assign lock1 = (state_q == LOCK1) & ~reset;

  assign m_tvalid  = (lock0 & s0_tvalid) | (lock1 & s1_tvalid);
  assign m_tlast   = (lock0 & s0_tlast)  | (lock1 & s1_tlast);
  assign m_tdata   = lock0 ? s0_tdata : (lock1 ? s1_tdata : '0);
  assign s0_tready = lock0 & m_tready;
  assign s1_tready = lock1 & m_tready;
  assign grant     = {lock1, lock0};
  assign busy      = lock0 | lock1;

  assign pkt_done  = m_tvalid & m_tready & m_tlast;

  always_ff @(posedge counter_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // On contention the source that was not served last wins.
          if (s0_tvalid & s1_tvalid) begin
            state_q <= last_served_q ? LOCK0 : LOCK1;
          end else if (s0_tvalid) begin
            state_q <= LOCK0;
          end else if (s1_tvalid) begin
            state_q <= LOCK1;
          end
        end
        LOCK0: begin
          if (pkt_done) begin
            state_q       <= IDLE;
            last_served_q <= 1'b0;
          end
        end
        LOCK1: begin
          if (pkt_done) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_PKT_COUNT_EN
  logic [CountWidth-1:0] pkt_count0_q;
  logic [CountWidth-1:0] pkt_count1_q;

  // Counters wrap naturally at 2^CountWidth.
  always_ff @(posedge counter_clk) begin
    if (reset) begin
      pkt_count0_q <= '0;
      pkt_count1_q <= '0;
    end else begin
      if (pkt_done & lock0) begin
        pkt_count0_q <= pkt_count0_q + CountWidth'(1);
      end
      if (pkt_done & lock1) begin
        pkt_count1_q <= pkt_count1_q + CountWidth'(1);
      end
    end
  end

  assign pkt_count0 = pkt_count0_q;
  assign pkt_count1 = pkt_count1_q;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - randomized self-checking bench for axis_pkt_arbiter
module tb_axis_pkt_arbiter;

  localparam int DW = 32;
`ifdef ARB_PKT_COUNT_EN
  localparam int CW   = 2;
  localparam int CMOD = 1 << CW;
  logic [CW-1:0] pkt_count0;
  logic [CW-1:0] pkt_count1;
`else
  localparam int CMOD = 65536;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tready, s0_tlast;
  logic          s1_tvalid, s1_tready, s1_tlast;
  logic          m_tvalid, m_tready, m_tlast;
  logic [1:0]    grant;
  logic          busy;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(
    .DataWidth (DW)
`ifdef ARB_PKT_COUNT_EN
    ,
    .CountWidth(CW)
`endif
  ) dut (
    .counter_clk(clk),
    .reset      (reset),
    .s0_tdata   (s0_tdata),
    .s0_tvalid  (s0_tvalid),
    .s0_tready  (s0_tready),
    .s0_tlast   (s0_tlast),
    .s1_tdata   (s1_tdata),
    .s1_tvalid  (s1_tvalid),
    .s1_tready  (s1_tready),
    .s1_tlast   (s1_tlast),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .grant      (grant),
    .busy       (busy)
`ifdef ARB_PKT_COUNT_EN
    ,
    .pkt_count0 (pkt_count0),
    .pkt_count1 (pkt_count1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pending beats per source as {tlast, tdata}; the head is what the source offers.
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  // DUT observations: accepted beats and grant at each completed packet.
  logic [DW:0] got_q[$];
  logic [1:0]  done_q[$];

  int vprob0, vprob1, rprob;
  bit rtoggle;

  // Reference model: who owns the output (-1 none), who was served last,
  // and completed packets per source.
  int owner;
  int ls;
  int cnt0, cnt1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_pkt(input int k, input int len, input logic [DW-1:0] base, input bit down);
    logic [DW:0] b;
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1), (down ? base - DW'(i) : base + DW'(i))};
      if (k == 0) q0.push_back(b);
      else        q1.push_back(b);
    end
  endtask

  task automatic drive();
    if (q0.size() > 0 && $urandom_range(99) < vprob0) begin
      s0_tvalid = 1'b1;
      {s0_tlast, s0_tdata} = q0[0];
    end else begin
      s0_tvalid = 1'b0;
      s0_tdata  = $urandom;
      s0_tlast  = 1'($urandom_range(1));
    end
    if (q1.size() > 0 && $urandom_range(99) < vprob1) begin
      s1_tvalid = 1'b1;
      {s1_tlast, s1_tdata} = q1[0];
    end else begin
      s1_tvalid = 1'b0;
      s1_tdata  = $urandom;
      s1_tlast  = 1'($urandom_range(1));
    end
    m_tready = rtoggle ? ~m_tready : ($urandom_range(99) < rprob);
  endtask

  // One clock cycle: check outputs mid-cycle, advance model at the edge,
  // then present the next inputs.
  task automatic step();
    logic v0, v1, l0, l1, rd, ev, el, xfer;
    logic [DW-1:0] d0, d1, ed;
    logic [1:0] eg;
    @(negedge clk);
    v0 = s0_tvalid; v1 = s1_tvalid; l0 = s0_tlast; l1 = s1_tlast;
    d0 = s0_tdata;  d1 = s1_tdata;  rd = m_tready;
    eg = 2'b00; ev = 1'b0; el = 1'b0; ed = '0;
    if (!reset && owner == 0) begin
      eg = 2'b01; ev = v0; el = l0; ed = d0;
    end else if (!reset && owner == 1) begin
      eg = 2'b10; ev = v1; el = l1; ed = d1;
    end
    chk("grant",     64'(grant),     64'(eg));
    chk("busy",      64'(busy),      64'(eg != 2'b00));
    chk("m_tvalid",  64'(m_tvalid),  64'(ev));
    chk("m_tdata",   64'(m_tdata),   64'(ed));
    chk("m_tlast",   64'(m_tlast),   64'(el));
    chk("s0_tready", 64'(s0_tready), 64'(eg[0] & rd));
    chk("s1_tready", 64'(s1_tready), 64'(eg[1] & rd));
`ifdef ARB_PKT_COUNT_EN
    chk("pkt_count0", 64'(pkt_count0), 64'(cnt0));
    chk("pkt_count1", 64'(pkt_count1), 64'(cnt1));
`endif
    if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    if (m_tvalid && m_tready && m_tlast) done_q.push_back(grant);
    xfer = ev & rd;
    @(posedge clk);
    if (reset) begin
      owner = -1; ls = 1; cnt0 = 0; cnt1 = 0;
    end else if (owner < 0) begin
      if (v0 && v1) owner = 1 - ls;
      else if (v0)  owner = 0;
      else if (v1)  owner = 1;
    end else if (xfer) begin
      if (owner == 0) void'(q0.pop_front());
      else            void'(q1.pop_front());
      if (el) begin
        if (owner == 0) cnt0 = (cnt0 + 1) % CMOD;
        else            cnt1 = (cnt1 + 1) % CMOD;
        ls = owner;
        owner = -1;
      end
    end
    #1;
    drive();
  endtask

  initial begin
    logic [DW:0] eb;
    logic [1:0]  eg;
    int guard;
    owner = -1; ls = 1; cnt0 = 0; cnt1 = 0;
    reset = 1'b1; m_tready = 1'b0;
    vprob0 = 0; vprob1 = 0; rprob = 100; rtoggle = 1'b0;
    drive();

    // Reset then idle.
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();

    // Single source: s1 counts down from FFFFFFFF.
    push_pkt(1, 4, 32'hFFFF_FFFF, 1'b1);
    vprob1 = 100;
    drive();
    got_q.delete();
    repeat (8) step();
    chk("single_beats", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      eb = {(i == 3), 32'hFFFF_FFFF - DW'(i)};
      chk("single_beat", 64'(got_q[i]), 64'(eb));
    end

    // Round-robin under contention with 3-beat packets.
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, 3, DW'(32'h100 * p), 1'b0);
      push_pkt(1, 3, DW'(32'hFFFF_F000 - 32'h100 * p), 1'b1);
    end
    vprob0 = 100; vprob1 = 100;
    drive();
    done_q.delete();
    repeat (40) step();
    chk("rr_pkts", 64'(done_q.size()), 64'd8);
    for (int i = 0; i < done_q.size(); i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_order", 64'(done_q[i]), 64'(eg));
    end

    // Backpressure: m_tready toggles during an s0 packet.
    push_pkt(0, 4, 32'hA5A5_0000, 1'b0);
    vprob0 = 100; vprob1 = 0; rtoggle = 1'b1; m_tready = 1'b0;
    drive();
    repeat (14) step();
    rtoggle = 1'b0;

    // Reset mid-packet: abandon a 5-beat s1 packet after two beats.
    push_pkt(1, 5, 32'h5000_0000, 1'b0);
    vprob0 = 0; vprob1 = 100;
    drive();
    got_q.delete();
    guard = 0;
    while (got_q.size() < 2 && guard < 20) begin
      step();
      guard++;
    end
    chk("beat2_wait", 64'(got_q.size()), 64'd2);
    reset = 1'b1;
    q0.delete(); q1.delete();
    push_pkt(0, 2, 32'h6000_0000, 1'b0);
    push_pkt(1, 2, 32'h7000_0000, 1'b0);
    vprob0 = 100; vprob1 = 100;
    drive();
    step();
    reset = 1'b0;
    step();
    step();
    chk("post_rst_grant", 64'(grant), 64'(2'b01));
    repeat (12) step();

`ifdef ARB_PKT_COUNT_EN
    // Counter wrap with CountWidth=2.
    reset = 1'b1;
    step();
    reset = 1'b0;
    q0.delete(); q1.delete();
    for (int p = 0; p < 5; p++) push_pkt(0, 2, DW'(32'h800 + 16 * p), 1'b0);
    vprob0 = 100; vprob1 = 0;
    drive();
    done_q.delete();
    guard = 0;
    for (int target = 1; target <= 5 && guard < 60; ) begin
      step();
      guard++;
      if (done_q.size() == target) begin
        chk("cnt_seq0", 64'(pkt_count0), 64'((target == 4) ? 0 : ((target == 5) ? 1 : target)));
        chk("cnt_seq1", 64'(pkt_count1), 64'd0);
        target++;
      end
    end
    chk("cnt_pkts", 64'(done_q.size()), 64'd5);
`endif

    // Randomized traffic with random valid, ready and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        vprob0 = $urandom_range(100);
        vprob1 = $urandom_range(100);
        rprob  = $urandom_range(20, 100);
      end
      if (q0.size() < 6) push_pkt(0, $urandom_range(1, 5), $urandom, 1'b0);
      if (q1.size() < 6) push_pkt(1, $urandom_range(1, 5), $urandom, 1'b1);
      reset = ($urandom_range(299) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular, two-input AXI-Stream arbiter for the Axis_Mux datapath. Shares one downstream stream between two streamer sources (count-up / count-down generators). Grants one source at a time and holds the grant until that source's `tlast` beat is accepted. Grants alternate round-robin, so a source that never drops `tvalid` cannot starve the other.

## Interface
Parameters:
- `DataWidth`, 32, width of all `tdata` buses
- `CountWidth`, 16, width of packet counters (only with `ARB_PKT_COUNT_EN`)

Ports:
- `counter_clk`  in  1  single clock; all logic is rising-edge
- `reset`  in  1  synchronous, active-high reset
- `s0_tdata`  in  DataWidth  source 0 data
- `s0_tvalid`  in  1  source 0 valid
- `s0_tready`  out  1  source 0 ready
- `s0_tlast`  in  1  source 0 end of packet
- `s1_tdata`, `s1_tvalid`, `s1_tready`, `s1_tlast`: as source 0, for source 1
- `m_tdata`  out  DataWidth  muxed output data
- `m_tvalid`  out  1  muxed output valid
- `m_tready`  in  1  downstream ready
- `m_tlast`  out  1  muxed output end of packet
- `grant`  out  2  one-hot current grant; 2'b00 when idle
- `busy`  out  1  high while a packet is locked
- `pkt_count0`, `pkt_count1`  out  CountWidth  completed packets per source (only with `ARB_PKT_COUNT_EN`)

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Reset state is IDLE.
- Register `last_served` (1 bit). Reset value is 1, so source 0 wins the first arbitration.
- IDLE:
  - `m_tvalid`=0, `s0_tready`=`s1_tready`=0, `grant`=00, `busy`=0.
  - If exactly one `sK_tvalid`=1, next state is LOCKK.
  - If both are 1, next state is LOCK of the source ≠ `last_served`.
  - If neither is 1, stay in IDLE.
- LOCKK:
  - `m_tdata`/`m_tvalid`/`m_tlast` = `sK_*`; `sK_tready` = `m_tready`; the other source's `tready`=0.
  - `grant`[K]=1, `busy`=1.
- A beat transfers when `m_tvalid & m_tready`. When the transferred beat has `m_tlast`=1:
  - next state is IDLE;
  - `last_served` ← K.
- In LOCK, the granted source dropping `tvalid` mid-packet does not release the grant. The lock is released only by a `tlast` beat.
- The ungranted source's `tvalid` is ignored while locked. Its data is held upstream by `tready`=0.
- Data outputs in IDLE: `m_tdata` = 0, `m_tlast` = 0.
- Reset mid-packet: the FSM returns to IDLE and `last_served`=1. The partial packet is abandoned; no beat is emitted in the reset cycle or the cycle after.

## Timing
- Reset values:
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0;
  - `s0_tready`=`s1_tready`=0;
  - `grant`=00, `busy`=0;
  - counters=0.
- Arbitration latency: `tvalid` sampled high in IDLE at edge N gives LOCK from edge N. The first beat is presentable in cycle N+1.
- Packet gap: exactly one IDLE cycle after each `tlast` beat, before the next grant.
- `m_tvalid`, `m_tdata`, `m_tlast` and `sK_tready` are combinational from the state register and the granted source or `m_tready`. Zero added data latency.
- Single-beat packet (`tvalid` & `tlast` together): 2-cycle period per packet (LOCK beat + IDLE).
- Simultaneous requests in IDLE are resolved by `last_served` only; no source has fixed priority.

## Configuration
- Macro `ARB_PKT_COUNT_EN`.
- Defined:
  - `pkt_count0`/`pkt_count1` ports exist.
  - A counter increments by 1 on each accepted `tlast` beat of its source.
  - Counters wrap from 2^CountWidth−1 to 0.
  - Counters are cleared by `reset`.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset then idle:
  - Stimulus: `reset`=1 for 2 cycles, no `tvalid`.
  - Required: `grant`=00, `m_tvalid`=0, both `tready`=0, and these hold for 10 cycles.
- Single source:
  - Stimulus: `s1` sends a 4-beat packet with data FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC; `m_tready`=1.
  - Required: `grant`=10 one cycle after `s1_tvalid`; 4 beats out in order; `m_tlast` on beat 4; IDLE next cycle.
- Round-robin under contention:
  - Stimulus: both sources hold `tvalid` continuously with 3-beat packets.
  - Required: grant order 0,1,0,1…; one IDLE cycle between packets; no interleaving of beats.
- Backpressure:
  - Stimulus: `m_tready` toggles 1,0,1,0 during an `s0` packet.
  - Required: `s0_tready` mirrors `m_tready`; `m_tdata` stable while `m_tready`=0; `s1_tready`=0 throughout.
- Reset mid-packet:
  - Stimulus: assert `reset` after beat 2 of a 5-beat `s1` packet, with both sources requesting afterwards.
  - Required: IDLE immediately; first post-reset grant=01.
- Counters (with `ARB_PKT_COUNT_EN`, `CountWidth`=2):
  - Stimulus: `s0` sends 5 packets.
  - Required: `pkt_count0` = 1,2,3,0,1; `pkt_count1` = 0.
